// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 receive FSM encoding and constants shared with the downstream scan-code decoder.
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int         FRAME_DATA_BITS = 8;
  localparam logic [7:0] BREAK_PREFIX    = 8'hF0;

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser followed by a stability filter for one raw PS/2 line.
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample matching the current output restarts the run of differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign line_o = filt_q;

endmodule

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 frame deserialiser presenting the last two valid bytes with status/err pulses.
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic        status,
  output logic        err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(FRAME_DATA_BITS);

  logic clk_f, data_f;
  logic clkn_q, tick;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_clk), .line_o(clk_f)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_data), .line_o(data_f)
  );

  // Rising-edge detect on the inverted filtered clock gives the falling-edge tick.
  assign tick = ~clk_f & ~clkn_q;

  ps2_state_e       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic             parity_q, parity_d;
  logic [15:0]      code_q, code_d;
  logic             status_q, status_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkn_q   <= 1'b0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      parity_q <= 1'b0;
      code_q   <= '0;
      status_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      clkn_q   <= ~clk_f;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      parity_q <= parity_d;
      code_q   <= code_d;
      status_q <= status_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    parity_d = parity_q;
    code_d   = code_q;
    status_d = 1'b0;
    err_d    = 1'b0;
    tmo_d    = '0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_f) begin
            shift_d  = '0;
            bitcnt_d = '0;
            state_d  = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_d  = {data_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(FRAME_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_f;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (data_f && odd_parity_ok(shift_q, parity_q)) begin
            code_d   = {code_q[7:0], shift_q};
            status_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A tick wins over an expiring timeout, so expiry is only evaluated without one.
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d  = ST_IDLE;
        shift_d  = '0;
        bitcnt_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  assign code   = code_q;
  assign status = status_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed scenario tests for ps2_frame_rx with hand-computed expectations.
`default_nettype none

module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] code;
  logic        status;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int st_hi = 0;
  int er_hi = 0;
  int both_hi = 0;
  int st0, er0;

  ps2_frame_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .status(status), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status) st_hi++;
    if (err) er_hi++;
    if (status && err) both_hi++;
  end

  // Sends the first n bits of {stop, parity, data, start}, LSB first.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 11);
  endtask

  task automatic snap();
    @(negedge clk);
    st0 = st_hi;
    er0 = er_hi;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (code !== 16'h0000) $display("FAIL reset_code: got %h expected 0000", code); else pass_cnt++;
    total_cnt++; if (status !== 1'b0) $display("FAIL reset_status: got %b expected 0", status); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d expected 0", dut.state_q); else pass_cnt++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_valid_frames();
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    @(negedge clk);
    total_cnt++; if (code !== 16'h00F0) $display("FAIL valid_first_code: got %h expected 00F0", code); else pass_cnt++;
    send_frame(8'h45, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (code !== 16'hF045) $display("FAIL valid_code: got %h expected F045", code); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 2) $display("FAIL valid_status_cycles: got %0d expected 2", st_hi - st0); else pass_cnt++;
    total_cnt++; if (er_hi - er0 !== 0) $display("FAIL valid_err_cycles: got %0d expected 0", er_hi - er0); else pass_cnt++;
  endtask

  task automatic test_bad_parity();
    snap();
    send_frame(8'h16, 1'b1, 1'b1);
    @(negedge clk);
    total_cnt++; if (er_hi - er0 !== 1) $display("FAIL parity_err_cycles: got %0d expected 1", er_hi - er0); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 0) $display("FAIL parity_status_cycles: got %0d expected 0", st_hi - st0); else pass_cnt++;
    total_cnt++; if (code !== 16'hF045) $display("FAIL parity_code: got %h expected F045", code); else pass_cnt++;
  endtask

  task automatic test_bad_stop();
    snap();
    send_frame(8'h16, 1'b0, 1'b0);
    @(negedge clk);
    total_cnt++; if (er_hi - er0 !== 1) $display("FAIL stop_err_cycles: got %0d expected 1", er_hi - er0); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 0) $display("FAIL stop_status_cycles: got %0d expected 0", st_hi - st0); else pass_cnt++;
    total_cnt++; if (code !== 16'hF045) $display("FAIL stop_code: got %h expected F045", code); else pass_cnt++;
  endtask

  task automatic test_timeout();
    snap();
    // Start bit plus five data bits of 0x16.
    send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 6);
    @(negedge clk);
    total_cnt++; if (dut.state_q !== ST_DATA) $display("FAIL timeout_partial_state: got %0d expected 1", dut.state_q); else pass_cnt++;
    repeat (TMO + 10) @(negedge clk);
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL timeout_state: got %0d expected 0", dut.state_q); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 0) $display("FAIL timeout_status_cycles: got %0d expected 0", st_hi - st0); else pass_cnt++;
    total_cnt++; if (er_hi - er0 !== 0) $display("FAIL timeout_err_cycles: got %0d expected 0", er_hi - er0); else pass_cnt++;
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (code !== 16'hF016) $display("FAIL timeout_after_code: got %h expected F016", code); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 2) $display("FAIL timeout_after_status: got %0d expected 2", st_hi - st0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    snap();
    ps2_data = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    ps2_data = 1'b1;
    @(negedge clk);
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL glitch_state: got %0d expected 0", dut.state_q); else pass_cnt++;
    send_bits(11'h7FF, 1);
    @(negedge clk);
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL spurious_start_state: got %0d expected 0", dut.state_q); else pass_cnt++;
    total_cnt++; if ((st_hi - st0) + (er_hi - er0) !== 0) $display("FAIL glitch_pulses: got %0d expected 0", (st_hi - st0) + (er_hi - er0)); else pass_cnt++;
    total_cnt++; if (code !== 16'hF016) $display("FAIL glitch_code: got %h expected F016", code); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    // Start bit plus four data bits, then reset while ps2_clk is high.
    send_bits({1'b1, 1'b1, 8'h45, 1'b0}, 5);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (code !== 16'h0000) $display("FAIL midreset_code: got %h expected 0000", code); else pass_cnt++;
    total_cnt++; if (status !== 1'b0) $display("FAIL midreset_status: got %b expected 0", status); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL midreset_err: got %b expected 0", err); else pass_cnt++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL midreset_state: got %0d expected 0", dut.state_q); else pass_cnt++;
    snap();
    send_frame(8'h45, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (code !== 16'h0045) $display("FAIL midreset_after_code: got %h expected 0045", code); else pass_cnt++;
    total_cnt++; if (st_hi - st0 !== 1) $display("FAIL midreset_after_status: got %0d expected 1", st_hi - st0); else pass_cnt++;
  endtask

  task automatic test_exclusive();
    total_cnt++; if (both_hi !== 0) $display("FAIL status_err_overlap: got %0d expected 0", both_hi); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_valid_frames();
    test_bad_parity();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the scan-code decoder.
- Synchronises and de-glitches the raw ps2_clk/ps2_data lines.
- Deserialises 11-bit PS/2 frames and checks parity and stop bit.
- Presents the two most recent valid bytes as code[15:0], with a one-cycle status pulse per accepted byte.
- A break sequence F0,45 therefore yields code=16'hF045 plus a status pulse, which the decoder edge-detects.

Parameters:
FILTER_CYCLES, 8, consecutive stable clk samples required before a synchronised PS/2 line is accepted as changed
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk
ps2_data  input  1  raw PS/2 data line, asynchronous to clk
code  output  16  {previous valid byte, latest valid byte}
status  output  1  one-cycle pulse when code has just been updated
err  output  1  one-cycle pulse on parity or stop-bit failure

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: code=16'h0000, status=0, err=0, FSM=IDLE, bit counter=0, timeout counter=0, filtered lines=1.
- Input conditioning:
  - Each raw line passes through a 2-FF synchroniser, then a stability filter.
  - The filtered output changes only after FILTER_CYCLES consecutive identical synchronised samples.
  - A falling edge of filtered ps2_clk is a one-cycle tick. ps2_data is sampled from its filtered value on that tick.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on tick with data=0 (start bit), clear shift register, bit count=0, go to DATA. On tick with data=1, stay in IDLE (spurious start).
  - DATA: on each tick shift in LSB first. After the 8th bit go to PARITY.
  - PARITY: on tick store the parity bit, go to STOP.
  - STOP: on tick, the frame is valid iff stop=1 and (XOR of 8 data bits XOR parity)=1 (odd parity). Always return to IDLE.
- Valid frame:
  - code <= {code[7:0], byte}.
  - status=1 for exactly the next cycle, then 0.
  - Latency: status asserts 1 cycle after the stop-bit tick; code is stable from that cycle until the next valid frame.
- Invalid frame: code unchanged, no status, err=1 for one cycle (same timing as status).
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on each tick.
  - At TIMEOUT_CYCLES, force IDLE, discard partial bits, no err, no status.
  - The counter is held at 0 in IDLE.
- Simultaneous events: a tick in the same cycle the timeout expires is treated as a tick (the counter clears and the FSM advances).
- status and err are never asserted together. Back-to-back frames each produce their own pulse.
- Reset mid-frame: immediate return to reset values; the next frame must begin with a fresh start bit.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding (IDLE/DATA/PARITY/STOP)
  - FRAME_DATA_BITS=8
  - BREAK_PREFIX=8'hF0 (shared with the decoder)
- One natural sub-module: ps2_line_filter (2-FF sync plus stability counter, parameterised by FILTER_CYCLES), instantiated once per line.
- Falling-edge detection reuses the existing red edge detector, driven by the inverted filtered ps2_clk.

Test Plan:
- Bytes F0 (parity 1), then 45 (parity 0), each a valid frame -> status pulses twice; after the second pulse code=16'hF045; err never asserts.
- Byte 16 sent with parity bit 1 (wrong) -> err pulses once, no status, code retains its prior value (16'hF045).
- Valid frame 16 with stop bit=0 -> err pulse, code unchanged.
- Start bit plus 5 data bits, then ps2_clk idle high for TIMEOUT_CYCLES+10 -> FSM back in IDLE with no pulses. A following valid F0,16 sequence -> code=16'hF016 with status.
- 3-cycle low glitch on ps2_clk in IDLE (FILTER_CYCLES=8) -> no tick, FSM stays IDLE. Tick with data=1 -> still IDLE.
- rst_n low for 2 cycles after the 4th data bit of a frame -> code=0, status=0, err=0. The next full valid 45 frame -> code=16'h0045, one status pulse.
